i2s_dac_transmitter: RTL and testbench
======================================

# i2s_dac_transmitter

Serialises 24-bit signed stereo samples, such as those from the sine/voice generators, into a Philips I2S stream for the board audio codec DAC.
- Runs in the 50 MHz system domain and generates BCLK and DACLRCK itself; the codec is a clock slave.
- Upstream hands samples in through a one-deep valid/ready holding register; one sample pair is consumed per audio frame.

## Interface
- `BCLK_HALF`, default 16: system clocks per BCLK half-period, ≥2. Frame = 64 BCLK = 128·BCLK_HALF clocks. Default gives 2048 clocks, 24.414 kHz at 50 MHz.
- `clk` in 1: system clock, the only clock in the block.
- `reset` in 1: synchronous, active-high.
- `sample_l` in 24: left sample, two's complement.
- `sample_r` in 24: right sample, two's complement.
- `sample_valid` in 1: sample pair offered.
- `sample_ready` out 1: holding register empty.
- `aud_bclk` out 1: bit clock.
- `aud_daclrck` out 1: word select; 0 = left, 1 = right.
- `aud_dacdat` out 1: serial data, MSB first.
- `frame_start` out 1: one-clk pulse when a frame is loaded.
- `underrun` out 1: one-clk pulse when a frame is loaded with no new sample.

## Operation
- **Divider.** `div_cnt` runs 0..BCLK_HALF-1. At terminal count `aud_bclk` toggles and `div_cnt` returns to 0.
  - A 1→0 toggle is a *fall event*.
- **Bit counter.** On each fall event `bit_cnt` (6 b) increments mod 64.
  - `aud_daclrck` = new `bit_cnt[5]`.
  - Slot index s = new `bit_cnt[4:0]`.
- **Data per slot.** s=0 → 0; s=1..24 → channel bit 24-s (MSB at s=1, the I2S one-BCLK delay); s=25..31 → 0.
  - Channel is left when `bit_cnt[5]`=0, right when 1.
- **Load.** At the fall event where `bit_cnt` becomes 0:
  - Holding register full: `cur_l/cur_r` ← holding contents; holding becomes empty.
  - Holding register empty: `cur_l/cur_r` keep their values (previous frame repeated) and `underrun` pulses.
  - `frame_start` pulses in either case.
- **Handshake.** `sample_ready` = !hold_full. A transfer occurs on a clk with `sample_valid && sample_ready`; both samples are captured and hold_full is set.
  - `sample_valid` may stay high; one pair is accepted per empty slot.
- **Simultaneous events.** A load with holding empty on the same clk as a transfer:
  - The frame underruns and repeats `cur`.
  - The incoming pair is captured into holding for the next frame. There is no bypass.
  - A load and a transfer with holding full cannot coincide, since ready=0.
- **Output encoding.** Samples are sent unmodified, as two's complement straight to the MSB.

## Timing
- **Reset values.** `div_cnt`=0, `aud_bclk`=0, `bit_cnt`=63, `aud_daclrck`=1, `aud_dacdat`=0, `cur_l/cur_r`=0, hold empty, `sample_ready`=1, `frame_start`=0, `underrun`=0.
- **Reset mid-frame.** Returns to the reset state on the next clk. No partial frame is completed.
- **First fall event after reset.**
  - Happens 2·BCLK_HALF clocks after reset deasserts: the rise is at clk BCLK_HALF, the fall at clk 2·BCLK_HALF.
  - `bit_cnt`→0 and the first load occurs.
- **Output registration.** `aud_bclk`, `aud_daclrck`, `aud_dacdat`, `frame_start` and `underrun` are registered.
  - Data and word select change on the same clk edge as the BCLK fall.
  - They are stable for BCLK_HALF clocks before the rising edge, where the codec samples.
- **Latency.** A sample pair accepted at clk t appears with its MSB at the next load + one BCLK.
  - Worst case is about one frame plus 2·BCLK_HALF clocks.
- **Ready timing.** `sample_ready` returns high one clk after the load that empties holding.

## Structure
- **Package `audio_pkg`:**
  - `SAMPLE_W`=24, `SLOT_W`=32.
  - `typedef logic signed [SAMPLE_W-1:0] sample_t`.
  - Shared with the sine/voice generators and the mixer.
- **Sub-module `i2s_clk_gen`:** contains `div_cnt`, `aud_bclk`, `bit_cnt` and `aud_daclrck`, and exports a `fall` strobe and `bit_cnt`.
- **Top level:** holds the holding register, `cur` registers, slot mux and pulse outputs.

## Test plan
- **Reset values.** Reset for 3 clks, then release → all outputs at reset values on cycle 0.
  - `aud_bclk` period = 32 clks and `aud_daclrck` period = 2048 clks (BCLK_HALF=16).
- **Bit pattern.** One pair offered before the first load: L=24'h800001, R=24'h7FFFFE.
  - Captured on rising BCLK edges, the left slot reads 0, then 1, 22×0, 1, then 7×0.
  - The right slot reads 0, then 0, 22×1, 0, then 7×0.
  - `frame_start` pulses once.
- **Underrun.** No sample offered for frame 2 → `underrun` pulses at the load and frame 2 repeats frame 1's bits exactly.
- **Back-pressure.** `sample_valid` held high with an incrementing sample:
  - `sample_ready` is low between accept and load, so exactly one accept per frame.
  - Serialized values increment by 1 per frame.
- **Simultaneous load and accept.** Valid asserted first on the exact load clk with holding empty:
  - `underrun` pulses.
  - The pair is accepted that clk and transmitted in the following frame.
- **Reset mid-frame.** Reset asserted at bit_cnt=40 → next clk is in the reset state; re-run the bit-pattern scenario and it passes.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types for the generators, mixer and I2S transmitter.
// Sample width, I2S slot width and the per-slot data bit selector.
package audio_pkg;

  localparam int SAMPLE_W = 24;
  localparam int SLOT_W   = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam logic [4:0] LAST_SLOT = 5'(SAMPLE_W);

  // Slot 0 is the I2S one-BCLK delay; MSB sits in slot 1.
  function automatic logic slot_bit(
    input sample_t    s,
    input logic [4:0] slot
  );
    logic [4:0] idx;
    logic       b;
    idx = LAST_SLOT - slot;
    b   = 1'b0;
    if (slot != 5'd0 && slot <= LAST_SLOT) begin
      b = s[idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider and 64-bit frame counter for the I2S transmitter.
// fall is high on the clk whose edge produces a BCLK 1->0 toggle.
module i2s_clk_gen #(
  parameter int BCLK_HALF = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic       fall,
  output logic [5:0] bit_cnt,
  output logic       aud_bclk,
  output logic       aud_daclrck
);

  localparam int DW = $clog2(BCLK_HALF);

  logic [DW-1:0] div_cnt;
  logic          term;
  logic [5:0]    bit_nxt;

  assign term    = div_cnt == DW'(BCLK_HALF - 1);
  assign fall    = term && aud_bclk;
  assign bit_nxt = bit_cnt + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      aud_bclk    <= 1'b0;
      bit_cnt     <= 6'd63;
      aud_daclrck <= 1'b1;
    end else if (term) begin
      div_cnt  <= '0;
      aud_bclk <= ~aud_bclk;
      if (aud_bclk) begin
        bit_cnt     <= bit_nxt;
        aud_daclrck <= bit_nxt[5];
      end
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_dac_transmitter.sv
// Philips I2S serialiser for 24-bit stereo samples, BCLK/LRCK master.
// One-deep holding register feeds one sample pair per 64-BCLK frame.
module i2s_dac_transmitter
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                frame_start,
  output logic                underrun
);

  logic       fall;
  logic [5:0] bit_cnt;
  logic [5:0] bit_nxt;
  logic       load;
  logic       xfer;
  logic       hold_full;
  sample_t    hold_l;
  sample_t    hold_r;
  sample_t    cur_l;
  sample_t    cur_r;
  sample_t    ch;
  logic       dat_nxt;

  i2s_clk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .fall       (fall),
    .bit_cnt    (bit_cnt),
    .aud_bclk   (aud_bclk),
    .aud_daclrck(aud_daclrck)
  );

  assign bit_nxt      = bit_cnt + 6'd1;
  assign load         = fall && (bit_cnt == 6'd63);
  assign sample_ready = !hold_full;
  assign xfer         = sample_valid && sample_ready;
  assign ch           = bit_nxt[5] ? cur_r : cur_l;
  assign dat_nxt      = slot_bit(ch, bit_nxt[4:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full   <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      cur_l       <= '0;
      cur_r       <= '0;
      aud_dacdat  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load && !hold_full;
      if (fall) begin
        aud_dacdat <= dat_nxt;
      end
      // An empty-hold load still lets a same-clk offer land in hold.
      if (load && hold_full) begin
        cur_l     <= hold_l;
        cur_r     <= hold_r;
        hold_full <= 1'b0;
      end else if (xfer) begin
        hold_l    <= sample_t'(sample_l);
        hold_r    <= sample_t'(sample_r);
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Directed bench for the I2S transmitter at BCLK_HALF=16.
// Frames are captured on rising BCLK and compared to hand-built slots.
module tb_i2s_dac_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sample_l;
  logic [23:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        frame_start;
  logic        underrun;

  i2s_dac_transmitter #(
    .BCLK_HALF(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_dacdat  (aud_dacdat),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] frame(
    input logic [23:0] l,
    input logic [23:0] r
  );
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  // Back-pressure source: valid held high, value bumps after each accept.
  bit          bp_on = 1'b0;
  bit          pend  = 1'b0;
  int          acc   = 0;
  logic [23:0] val;

  initial begin
    forever begin
      @(negedge clk);
      if (bp_on) begin
        if (pend) begin
          val      = val + 24'd1;
          sample_l = val;
          sample_r = ~val;
          pend     = 1'b0;
        end
        if (!sample_valid) begin
          sample_l     = val;
          sample_r     = ~val;
          sample_valid = 1'b1;
        end
        if (sample_ready) begin
          pend = 1'b1;
          acc++;
        end
      end
    end
  end

  task automatic wait_fs(output int at, output logic ur);
    int g;
    g  = 0;
    at = -1;
    ur = 1'b0;
    while (g < 4200 && at < 0) begin
      @(negedge clk);
      g++;
      if (frame_start) begin
        at = cyc;
        ur = underrun;
      end
    end
    if (at < 0) check("fs_timeout", 64'd0, 64'd1);
  endtask

  task automatic cap(output logic [63:0] b, output int per);
    int   got;
    int   last;
    int   guard;
    logic pb;
    got   = 0;
    last  = 0;
    guard = 0;
    per   = 0;
    b     = '0;
    pb    = aud_bclk;
    while (got < 64 && guard < 2200) begin
      @(negedge clk);
      guard++;
      if (aud_bclk && !pb) begin
        b = {b[62:0], aud_dacdat};
        if (got == 1) per = cyc - last;
        last = cyc;
        got++;
      end
      pb = aud_bclk;
    end
    if (got < 64) check("cap_timeout", 64'(got), 64'd64);
  endtask

  task automatic chk_rst(input string p);
    check({p, "_bclk"},  64'(aud_bclk),     64'd0);
    check({p, "_lrck"},  64'(aud_daclrck),  64'd1);
    check({p, "_dat"},   64'(aud_dacdat),   64'd0);
    check({p, "_ready"}, 64'(sample_ready), 64'd1);
    check({p, "_fs"},    64'(frame_start),  64'd0);
    check({p, "_ur"},    64'(underrun),     64'd0);
  endtask

  task automatic run_pattern(input string p);
    logic [63:0] b;
    int          per;
    int          fs1;
    int          fs2;
    int          n;
    int          rise;
    logic        ur;
    logic        lr;
    reset = 1'b0;
    chk_rst({p, "_rst"});
    sample_l     = 24'h800001;
    sample_r     = 24'h7FFFFE;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check({p, "_ready_lo"}, 64'(sample_ready), 64'd0);
    n    = 1;
    rise = 0;
    fs1  = -1;
    ur   = 1'b1;
    lr   = 1'b1;
    while (n < 100 && fs1 < 0) begin
      if (aud_bclk && rise == 0) rise = n;
      if (frame_start) begin
        fs1 = cyc;
        ur  = underrun;
        lr  = aud_daclrck;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check({p, "_rise_at"}, 64'(rise), 64'd16);
    check({p, "_fall_at"}, 64'(n),    64'd32);
    check({p, "_ur1"},     64'(ur),   64'd0);
    check({p, "_lrck1"},   64'(lr),   64'd0);
    cap(b, per);
    check({p, "_bits1"},   b,         64'h00800001007FFFFE & 64'hFFFFFFFFFFFFFFFF ? {1'b0, 24'h800001, 7'b0, 1'b0, 24'h7FFFFE, 7'b0} : 64'd0);
    check({p, "_bper"},    64'(per),  64'd32);
    wait_fs(fs2, ur);
    check({p, "_fper"},    64'(fs2 - fs1), 64'd2048);
    check({p, "_ur2"},     64'(ur),   64'd1);
    cap(b, per);
    check({p, "_bits2"},   b,         frame(24'h800001, 24'h7FFFFE));
  endtask

  initial begin
    logic [63:0] b;
    int          per;
    int          f;
    int          a0;
    logic        ur;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    val          = '0;
    repeat (3) @(negedge clk);
    run_pattern("p1");

    val   = 24'h000100;
    bp_on = 1'b1;
    wait_fs(f, ur);
    check("bp3_ur", 64'(ur), 64'd0);
    cap(b, per);
    check("bp3_bits", b, frame(24'h000100, 24'hFFFEFF));
    check("bp3_acc", 64'(acc), 64'd2);
    a0 = acc;
    wait_fs(f, ur);
    check("bp4_ur", 64'(ur), 64'd0);
    cap(b, per);
    check("bp4_bits", b, frame(24'h000101, 24'hFFFEFE));
    check("bp4_acc", 64'(acc - a0), 64'd1);
    wait_fs(f, ur);
    cap(b, per);
    check("bp5_bits", b, frame(24'h000102, 24'hFFFEFD));
    check("bp5_acc", 64'(acc), 64'd4);
    bp_on        = 1'b0;
    sample_valid = 1'b0;

    wait_fs(f, ur);
    check("f6_ur", 64'(ur), 64'd0);
    cap(b, per);
    check("f6_bits", b, frame(24'h000103, 24'hFFFEFC));
    while (cyc < f + 2047) @(negedge clk);
    sample_l     = 24'hA5A5A5;
    sample_r     = 24'h5A5A5A;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("sim_fs", 64'(frame_start), 64'd1);
    check("sim_ur", 64'(underrun), 64'd1);
    check("sim_ready", 64'(sample_ready), 64'd0);
    cap(b, per);
    check("f7_bits", b, frame(24'h000103, 24'hFFFEFC));
    wait_fs(f, ur);
    check("f8_ur", 64'(ur), 64'd0);
    cap(b, per);
    check("f8_bits", b, frame(24'hA5A5A5, 24'h5A5A5A));

    wait_fs(f, ur);
    check("f9_ur", 64'(ur), 64'd1);
    sample_l     = 24'h123456;
    sample_r     = 24'h654321;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("mid_ready_lo", 64'(sample_ready), 64'd0);
    while (cyc < f + 40 * 32 + 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_rst("mid");
    run_pattern("p2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
